// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data ports.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // fetch port
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  // data port
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          err_o,
  // memory side
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  // hazard unit
  output logic          stall_if_o,
  output logic          stall_mem_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD, StDone} state_e;

  state_e        state_q, state_d;
  // Owner of the current/most recent access (1 = data); doubles as last_owner for round-robin.
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          gnt_q, gnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_d;
  logic          busy;

`ifdef ARB_RR_EN
  // On a tie, serve the port that did not own the previous access.
  assign pick_d = d_req_i & (~if_req_i | ~owner_q);
`else
  assign pick_d = d_req_i;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    gnt_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (d_req_i || if_req_i) begin
          owner_d = pick_d;
          gnt_d   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (pick_d) begin
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            state_d = StBusyD;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
            state_d = StBusyIf;
          end
        end
      end
      StBusyIf, StBusyD: begin
        if (mem_ack_i) begin
          if (state_q == StBusyIf) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata_i;
          end
          state_d = StDone;
        end else if (cnt_q == TimeoutVal) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      gnt_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    busy        = (state_q == StBusyIf) || (state_q == StBusyD);
    mem_req_o   = busy;
    mem_we_o    = busy & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_gnt_o    = gnt_q & ~owner_q;
    d_gnt_o     = gnt_q & owner_q;
    if_rvalid_o = (state_q == StDone) & ~owner_q;
    d_rvalid_o  = (state_q == StDone) & owner_q;
    err_o       = (state_q == StDone) & err_q;
    if_rdata_o  = if_rdata_q;
    d_rdata_o   = d_rdata_q;
    stall_if_o  = if_req_i & ~if_rvalid_o;
    stall_mem_o = d_req_i & ~d_rvalid_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences, random vs. model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          if_req_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic          err_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          stall_if_o, stall_mem_o;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last returned words per port and who was served last (1 = data).
  logic [31:0] m_if, m_dr;
  bit          m_last_d;

  typedef struct {
    bit          dreq, ireq, we;
    logic [31:0] daddr, dwdata, iaddr, rdata;
    int          delay;  // ack arrives in busy cycle delay+1; delay > TO means no ack
    bit          exp_d, exp_err;
    logic [31:0] exp_if, exp_dr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit model_pick(input bit dreq, input bit ireq, input bit last_d);
`ifdef ARB_RR_EN
    if (dreq && ireq) return !last_d;
    return dreq;
`else
    return dreq;
`endif
  endfunction

  // One full access starting in an IDLE cycle; ends in the following IDLE cycle.
  task automatic txn(input bit dreq, input bit ireq, input bit we, input logic [31:0] daddr,
                     input logic [31:0] dwdata, input logic [31:0] iaddr,
                     input logic [31:0] rdata, input int delay, input bit scramble,
                     input bit exp_d, input bit exp_err, input logic [31:0] exp_if,
                     input logic [31:0] exp_dr);
    int busy;
    busy = (delay <= TO) ? delay + 1 : TO + 1;
    d_req_i = dreq; if_req_i = ireq; d_we_i = we;
    d_addr_i = daddr; d_wdata_i = dwdata; if_addr_i = iaddr; mem_ack_i = 1'b0;
    #1;
    chk("c0_mem_req", mem_req_o, 0);
    chk("c0_stall_mem", stall_mem_o, dreq);
    chk("c0_stall_if", stall_if_o, ireq);
    for (int c = 1; c <= busy; c++) begin
      tick();
      if (scramble) begin
        d_addr_i = $urandom; d_wdata_i = $urandom; if_addr_i = $urandom;
        d_we_i = 1'($urandom_range(0, 1));
      end
      mem_ack_i   = (c == delay + 1);
      mem_rdata_i = (c == delay + 1) ? rdata : $urandom;
      #1;
      chk("busy_mem_req", mem_req_o, 1);
      chk("busy_mem_addr", mem_addr_o, exp_d ? daddr : iaddr);
      chk("busy_mem_we", mem_we_o, exp_d & we);
      if (exp_d && we) chk("busy_mem_wdata", mem_wdata_o, dwdata);
      chk("busy_d_gnt", d_gnt_o, (c == 1) && exp_d);
      chk("busy_if_gnt", if_gnt_o, (c == 1) && !exp_d);
      chk("busy_stall_mem", stall_mem_o, dreq);
      chk("busy_stall_if", stall_if_o, ireq);
      chk("busy_rvalid", {d_rvalid_o, if_rvalid_o, err_o}, 0);
    end
    tick();
    mem_ack_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    #1;
    chk("done_d_rvalid", d_rvalid_o, exp_d);
    chk("done_if_rvalid", if_rvalid_o, !exp_d);
    chk("done_err", err_o, exp_err);
    chk("done_mem_req", mem_req_o, 0);
    chk("done_if_rdata", if_rdata_o, exp_if);
    chk("done_d_rdata", d_rdata_o, exp_dr);
    chk("done_stall_winner", exp_d ? stall_mem_o : stall_if_o, 0);
    if (exp_d) d_req_i = 1'b0;
    else if_req_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("idle_quiet", {mem_req_o, d_rvalid_o, if_rvalid_o, err_o, d_gnt_o, if_gnt_o}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          ed, ee, dreq, ireq, we;
    int          dly;
    logic [31:0] rd;
    bit          conf_exp[4];

    rst_ni = 1'b0;
    if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h40, 32'h00500093, 0,
                1'b0, 1'b0, 32'h00500093, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h12345678, 3,
                1'b1, 1'b0, 32'h00500093, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'hCAFEF00D, 1,
                1'b1, 1'b0, 32'h00500093, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 32'hBADBAD00, TO + 1,
                1'b1, 1'b1, 32'h00500093, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h0, 32'h11111111, TO,
                1'b1, 1'b0, 32'h00500093, 32'h11111111};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h44, 32'h77777777, TO + 1,
                1'b0, 1'b1, 32'h00500093, 32'h11111111};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h48, 32'h00A00113, 2,
                1'b0, 1'b0, 32'h00A00113, 32'h11111111};

    #12;
    chk("rst_outputs", {mem_req_o, mem_we_o, err_o, d_gnt_o, if_gnt_o, d_rvalid_o, if_rvalid_o},
        0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].dreq, vecs[i].ireq, vecs[i].we, vecs[i].daddr, vecs[i].dwdata, vecs[i].iaddr,
          vecs[i].rdata, vecs[i].delay, 1'b0, vecs[i].exp_d, vecs[i].exp_err, vecs[i].exp_if,
          vecs[i].exp_dr);
    end

    // Reset in the middle of a data load, between clock edges.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300;
    tick();
    tick();
    #2;
    chk("pre_rst_busy", mem_req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_req_o, 0);
    chk("rst_async_mem_addr", mem_addr_o, 0);
    chk("rst_async_rdata", {if_rdata_o, d_rdata_o}, 0);
    d_req_i = 0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    mem_ack_i = 1; mem_rdata_i = 32'hAAAA5555;
    #1;
    chk("stray_ack_c0", {mem_req_o, d_rvalid_o, if_rvalid_o, err_o}, 0);
    tick();
    mem_ack_i = 0;
    #1;
    chk("stray_ack_c1", {mem_req_o, d_rvalid_o, if_rvalid_o, err_o}, 0);
    chk("stray_ack_rdata", {if_rdata_o, d_rdata_o}, 0);
    tick();
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h500, 32'h13572468, 1, 1'b0,
        1'b0, 1'b0, 32'h13572468, 32'h0);
    m_if = 32'h13572468; m_dr = 32'h0; m_last_d = 1'b0;

    // Both ports requesting for four consecutive accesses.
`ifdef ARB_RR_EN
    conf_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    conf_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      rd = 32'hC0DE0000 + 32'(i);
      if (conf_exp[i]) m_dr = rd;
      else m_if = rd;
      txn(1'b1, 1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'h0, 32'h700 + 32'(4 * i), rd, i, 1'b0,
          conf_exp[i], 1'b0, m_if, m_dr);
      m_last_d = conf_exp[i];
    end

    // Random accesses against the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: begin dreq = 1; ireq = 0; end
        1: begin dreq = 0; ireq = 1; end
        default: begin dreq = 1; ireq = 1; end
      endcase
      we  = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, TO + 1);
      rd  = $urandom;
      ed  = model_pick(dreq, ireq, m_last_d);
      ee  = dly > TO;
      if (!ee) begin
        if (!ed) m_if = rd;
        else if (!we) m_dr = rd;
      end
      m_last_d = ed;
      txn(dreq, ireq, we, $urandom, $urandom, $urandom, rd, dly, 1'b1, ed, ee, m_if, m_dr);
    end
    d_req_i = 0;
    if_req_i = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
